mem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage: it sequences one load or store per instruction over the SRAM-like data bus, stalling the pipeline until the bus completes. For each access it generates the byte strobes, the lane-replicated write data and the size field, and it detects misaligned addresses. It also extracts and sign- or zero-extends load data (lb/lbu/lh/lhu/lw), so `rdataM` is the final writeback value.

---
 rtl/mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store per instruction over an SRAM-like bus,
// with strobe/lane generation, misalignment detection and load-data extension.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memenM,
    input  logic [2:0]  opM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        flushM,
    output logic        stallM,
    output logic [31:0] rdataM,
    output logic        validM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpLb  = 3'd1;
    localparam logic [2:0] OpLbu = 3'd2;
    localparam logic [2:0] OpLh  = 3'd3;
    localparam logic [2:0] OpLhu = 3'd4;
    localparam logic [2:0] OpSw  = 3'd5;
    localparam logic [2:0] OpSb  = 3'd6;
    localparam logic [2:0] OpSh  = 3'd7;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;

    logic        is_store;
    logic        aligned;
    logic        access;
    logic        start;
    logic        op_q_store;
    logic        load_done;
    logic [1:0]  size_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request-side decode of the incoming instruction
    always_comb begin
        is_store = 1'b0;
        aligned  = 1'b1;
        size_d   = 2'd0;
        wdata_d  = 32'h0;
        wstrb_d  = 4'b0000;
        case (opM)
            OpLw: begin
                aligned = (addrM[1:0] == 2'b00);
                size_d  = 2'd2;
            end
            OpLh, OpLhu: begin
                aligned = ~addrM[0];
                size_d  = 2'd1;
            end
            OpSw: begin
                is_store = 1'b1;
                aligned  = (addrM[1:0] == 2'b00);
                size_d   = 2'd2;
                wdata_d  = wdataM;
                wstrb_d  = 4'b1111;
            end
            OpSb: begin
                is_store = 1'b1;
                wdata_d  = {4{wdataM[7:0]}};
                wstrb_d  = 4'b0001 << addrM[1:0];
            end
            OpSh: begin
                is_store = 1'b1;
                aligned  = ~addrM[0];
                size_d   = 2'd1;
                wdata_d  = {2{wdataM[15:0]}};
                wstrb_d  = addrM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                // lb, lbu: byte accesses are always aligned
                size_d = 2'd0;
            end
        endcase
    end

    assign access    = memenM & ~flushM;
    assign start     = (state_q == StIdle) & access & aligned;
    assign adelM     = (state_q == StIdle) & access & ~aligned & ~is_store;
    assign adesM     = (state_q == StIdle) & access & ~aligned & is_store;
    assign badvaddrM = addrM;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    // Next-state logic; a flush after the address was accepted must drain the data beat
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StAddr;
                    cancel_d = 1'b0;
                end
            end
            StAddr: begin
                if (data_addr_ok) begin
                    cancel_d = flushM;
                    if (data_data_ok) begin
                        state_d = flushM ? StIdle : StDone;
                    end else begin
                        state_d = StData;
                    end
                end else if (flushM) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (flushM) begin
                    cancel_d = 1'b1;
                end
                if (data_data_ok) begin
                    state_d = (cancel_q | flushM) ? StIdle : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        stallM    = 1'b0;
        validM    = 1'b0;
        load_done = 1'b0;
        case (state_q)
            StIdle: stallM = start;
            StAddr: begin
                stallM    = 1'b1;
                load_done = data_addr_ok & data_data_ok & ~flushM & ~op_q_store;
            end
            StData: begin
                stallM    = 1'b1;
                load_done = data_data_ok & ~cancel_q & ~flushM & ~op_q_store;
            end
            StDone: validM = 1'b1;
            default: begin
                stallM = 1'b0;
            end
        endcase
    end

    assign op_q_store = (op_q == OpSw) | (op_q == OpSb) | (op_q == OpSh);

    // Bus request registers; fields stay stable while data_req waits for addr_ok
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'h0;
            data_wdata <= 32'h0;
            data_wstrb <= 4'b0000;
        end else if (start) begin
            data_req   <= 1'b1;
            data_wr    <= is_store;
            data_size  <= size_d;
            data_addr  <= addrM;
            data_wdata <= wdata_d;
            data_wstrb <= wstrb_d;
        end else if ((state_q == StAddr) && (data_addr_ok || flushM)) begin
            data_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= OpLw;
            lane_q <= 2'b00;
        end else if (start) begin
            op_q   <= opM;
            lane_q <= addrM[1:0];
        end
    end

    // Load lane extraction and extension
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = data_rdata[7:0];
            2'd1:    byte_sel = data_rdata[15:8];
            2'd2:    byte_sel = data_rdata[23:16];
            default: byte_sel = data_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (op_q)
            OpLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_val = {24'h0, byte_sel};
            OpLh:    load_val = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_val = {16'h0, half_sel};
            default: load_val = data_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdataM <= 32'h0;
        end else if (load_done) begin
            rdataM <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl: transaction-level timeline model
// with a per-cycle compare process and a few literal pins.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        memenM = 1'b0;
    logic [2:0]  opM = 3'd0;
    logic [31:0] addrM = 32'h0;
    logic [31:0] wdataM = 32'h0;
    logic        flushM = 1'b0;
    logic        stallM;
    logic [31:0] rdataM;
    logic        validM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badvaddrM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    mem_access_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .memenM       (memenM),
        .opM          (opM),
        .addrM        (addrM),
        .wdataM       (wdataM),
        .flushM       (flushM),
        .stallM       (stallM),
        .rdataM       (rdataM),
        .validM       (validM),
        .adelM        (adelM),
        .adesM        (adesM),
        .badvaddrM    (badvaddrM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_seen = 0;

    logic        exp_stall = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_adel = 1'b0;
    logic        exp_ades = 1'b0;
    logic [31:0] exp_badv = 32'h0;
    logic        exp_req = 1'b0;
    logic        exp_wr = 1'b0;
    logic [1:0]  exp_size = 2'd0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_strb = 4'b0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_load(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd5:       return 4;
            3'd3, 3'd4, 3'd7: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(op)) != 0;
    endfunction

    function automatic logic [31:0] st_wdata(input logic [2:0] op, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = nbytes(op);
        r = 32'h0;
        if (!is_load(op)) begin
            for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] op, input logic [31:0] addr);
        int m;
        if (is_load(op)) return 4'b0;
        m = ((1 << nbytes(op)) - 1) << int'(addr[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] r);
        int n;
        logic [31:0] mask;
        logic [31:0] v;
        n = nbytes(op);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = (r >> (8 * int'(a))) & mask;
        if ((op == 3'd1 || op == 3'd3) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_fields(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] w);
        int n;
        n = nbytes(op);
        exp_wr    = !is_load(op);
        exp_size  = (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
        exp_addr  = addr;
        exp_wdata = st_wdata(op, w);
        exp_strb  = st_strb(op, addr);
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        check("stallM", 32'(stallM), 32'(exp_stall));
        check("validM", 32'(validM), 32'(exp_valid));
        check("adelM", 32'(adelM), 32'(exp_adel));
        check("adesM", 32'(adesM), 32'(exp_ades));
        if (exp_adel || exp_ades) check("badvaddrM", badvaddrM, exp_badv);
        check("data_req", 32'(data_req), 32'(exp_req));
        check("data_wr", 32'(data_wr), 32'(exp_wr));
        check("data_size", 32'(data_size), 32'(exp_size));
        check("data_addr", data_addr, exp_addr);
        check("data_wdata", data_wdata, exp_wdata);
        check("data_wstrb", 32'(data_wstrb), 32'(exp_strb));
        check("rdataM", rdataM, exp_rdata);
        if (stallM) stall_seen++;
    end

    // ---------------- stimulus ----------------
    // aw: cycles of req before addr_ok; dw: cycles from addr_ok to data_ok;
    // f: cycle (relative to start) from which flushM is held, 0 for none.
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int aw, input int dw, input int f);
        bit mis;
        bit kill;
        bit flushed;
        int total;
        int last;
        mis     = misaligned(op, addr);
        flushed = (f >= 1);
        kill    = flushed && (f < aw + 1);
        total   = aw + 2 + dw;
        last    = mis ? 0 : (kill ? f + 1 : total);
        for (int c = 0; c <= last; c++) begin
            memenM       = 1'b1;
            opM          = op;
            addrM        = addr;
            wdataM       = wdata;
            flushM       = flushed && (c >= f);
            data_addr_ok = !mis && !kill && (c == aw + 1);
            data_data_ok = !mis && !kill && (c == aw + 1 + dw);
            data_rdata   = data_data_ok ? rdata : $urandom;
            exp_req      = !mis && (c >= 1) && (c <= (kill ? f : aw + 1));
            exp_stall    = !mis && (c < last);
            exp_valid    = !mis && !flushed && (c == total);
            exp_adel     = mis && is_load(op);
            exp_ades     = mis && !is_load(op);
            exp_badv     = addr;
            if (c == 1) set_fields(op, addr, wdata);
            if (!mis && !flushed && is_load(op) && c == total)
                exp_rdata = ld_val(op, addr[1:0], rdata);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            memenM       = 1'($urandom_range(0, 1));
            flushM       = memenM ? 1'b1 : 1'($urandom_range(0, 1));
            opM          = 3'($urandom);
            addrM        = $urandom;
            wdataM       = $urandom;
            data_addr_ok = 1'($urandom_range(0, 1));
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            exp_req      = 1'b0;
            exp_stall    = 1'b0;
            exp_valid    = 1'b0;
            exp_adel     = 1'b0;
            exp_ades     = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_mid_data();
        for (int c = 0; c < 3; c++) begin
            memenM       = 1'b1;
            opM          = 3'd0;
            addrM        = 32'h0000_5000;
            wdataM       = $urandom;
            flushM       = 1'b0;
            data_addr_ok = (c == 1);
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            exp_req      = (c == 1);
            exp_stall    = 1'b1;
            exp_valid    = 1'b0;
            exp_adel     = 1'b0;
            exp_ades     = 1'b0;
            if (c == 1) set_fields(3'd0, 32'h0000_5000, wdataM);
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        // Now in the data phase; pull reset between edges
        #1;
        resetn       = 1'b0;
        memenM       = 1'b0;
        data_addr_ok = 1'b0;
        exp_req      = 1'b0;
        exp_stall    = 1'b0;
        exp_wr       = 1'b0;
        exp_size     = 2'd0;
        exp_addr     = 32'h0;
        exp_wdata    = 32'h0;
        exp_strb     = 4'b0;
        exp_rdata    = 32'h0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int s0;
        logic [2:0]  op;
        logic [31:0] addr;
        int aw;
        int dw;
        int f;

        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        run_idle(2);

        s0 = stall_seen;
        run_access(3'd1, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 0, 0, 0);
        check("lb_stall_cycles", 32'(stall_seen - s0), 32'd2);
        check("lb_rdata", rdataM, 32'hFFFF_FF80);

        s0 = stall_seen;
        run_access(3'd4, 32'h0000_1002, 32'h0, 32'h8123_4567, 2, 1, 0);
        check("lhu_stall_cycles", 32'(stall_seen - s0), 32'd5);
        check("lhu_rdata", rdataM, 32'h0000_8123);

        run_access(3'd7, 32'h0000_2002, 32'h1234_ABCD, $urandom, 1, 0, 0);
        check("sh_wdata", data_wdata, 32'hABCD_ABCD);
        check("sh_wstrb", 32'(data_wstrb), 32'hC);
        check("sh_size", 32'(data_size), 32'd1);
        check("sh_wr", 32'(data_wr), 32'd1);
        check("sh_rdata_kept", rdataM, 32'h0000_8123);

        run_access(3'd0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
        run_access(3'd7, 32'h0000_3001, 32'h5555_AAAA, 32'h0, 0, 0, 0);
        run_idle(1);

        s0 = stall_seen;
        run_access(3'd0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 2, 0, 1);
        check("flush_addr_stall", 32'(stall_seen - s0), 32'd2);
        check("flush_addr_rdata", rdataM, 32'h0000_8123);

        s0 = stall_seen;
        run_access(3'd0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0, 3, 2);
        check("flush_data_stall", 32'(stall_seen - s0), 32'd5);
        check("flush_data_rdata", rdataM, 32'h0000_8123);

        reset_mid_data();
        run_idle(1);
        run_access(3'd6, 32'h0000_0000, 32'h0000_0042, $urandom, 0, 0, 0);
        check("sb_after_reset_strb", 32'(data_wstrb), 32'h1);

        for (int i = 0; i < 80; i++) begin
            op   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 9) < 7) addr = addr & ~32'(nbytes(op) - 1);
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            f  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, aw + 1 + dw) : 0;
            run_access(op, addr, $urandom, $urandom, aw, dw, f);
            run_idle($urandom_range(0, 2));
        end

        run_idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
